// File: rtl/mod_dma_agen.sv
// mod_dma_agen: multi-channel strided DMA address generator with
// start/busy/done handshake and per-channel ready back-pressure.
// Optional abort port/flag enabled by defining MOD_DMA_AGEN_ABORT_EN.
module mod_dma_agen #(
    parameter int unsigned NCH    = 2,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NCH*ADDR_W-1:0] cfg_base,
    input  logic [NCH*ADDR_W-1:0] cfg_stride,
    input  logic [NCH*LEN_W-1:0]  cfg_len,
    input  logic [NCH-1:0]        ready,
`ifdef MOD_DMA_AGEN_ABORT_EN
    input  logic                  abort,
    output logic                  aborted,
`endif
    output logic [NCH*ADDR_W-1:0] addr,
    output logic [NCH-1:0]        addr_vld,
    output logic [NCH-1:0]        addr_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] stride_q [NCH];
    logic [ADDR_W-1:0] stride_d [NCH];
    logic [LEN_W-1:0]  len_q    [NCH];
    logic [LEN_W-1:0]  len_d    [NCH];
    logic [ADDR_W-1:0] addr_q   [NCH];
    logic [ADDR_W-1:0] addr_d   [NCH];
    logic [LEN_W-1:0]  idx_q    [NCH];
    logic [LEN_W-1:0]  idx_d    [NCH];
    logic [NCH-1:0]    vld_q, vld_d;
    logic [NCH-1:0]    last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef MOD_DMA_AGEN_ABORT_EN
    logic              aborted_q, aborted_d;
`endif

    logic              any_en;
    logic              any_vld;
    logic [ADDR_W-1:0] cfg_base_c;
    logic [LEN_W-1:0]  cfg_len_c;

    // Next-state and per-channel beat logic
    always_comb begin
        state_d = state_q;
        stride_d = stride_q;
        len_d = len_q;
        addr_d = addr_q;
        idx_d = idx_q;
        vld_d = vld_q;
        last_d = last_q;
`ifdef MOD_DMA_AGEN_ABORT_EN
        aborted_d = 1'b0;
`endif
        any_en = 1'b0;
        any_vld = 1'b0;
        cfg_base_c = '0;
        cfg_len_c = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    for (int c = 0; c < NCH; c++) begin
                        cfg_base_c  = cfg_base[c*ADDR_W +: ADDR_W];
                        cfg_len_c   = cfg_len[c*LEN_W +: LEN_W];
                        stride_d[c] = cfg_stride[c*ADDR_W +: ADDR_W];
                        len_d[c]    = cfg_len_c;
                        idx_d[c]    = '0;
                        vld_d[c]    = (cfg_len_c != '0);
                        last_d[c]   = (cfg_len_c == LEN_W'(1));
                        addr_d[c]   = (cfg_len_c != '0) ? cfg_base_c : '0;
                        any_en      = any_en | (cfg_len_c != '0);
                    end
                    state_d = any_en ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                for (int c = 0; c < NCH; c++) begin
                    if (vld_q[c] && ready[c]) begin
                        if (last_q[c]) begin
                            vld_d[c]  = 1'b0;
                            last_d[c] = 1'b0;
                        end else begin
                            addr_d[c] = ADDR_W'(addr_q[c] + stride_q[c]);
                            idx_d[c]  = LEN_W'(idx_q[c] + LEN_W'(1));
                            last_d[c] = (LEN_W'(idx_q[c] + LEN_W'(1)) ==
                                         LEN_W'(len_q[c] - LEN_W'(1)));
                        end
                    end
                    any_vld = any_vld | vld_d[c];
                end
                if (!any_vld) begin
                    state_d = ST_DONE;
                end
`ifdef MOD_DMA_AGEN_ABORT_EN
                // Abort overrides any same-edge completion
                if (abort) begin
                    for (int c = 0; c < NCH; c++) begin
                        vld_d[c]  = 1'b0;
                        last_d[c] = 1'b0;
                        addr_d[c] = '0;
                    end
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            for (int c = 0; c < NCH; c++) begin
                stride_q[c] <= '0;
                len_q[c]    <= '0;
                addr_q[c]   <= '0;
                idx_q[c]    <= '0;
            end
            vld_q     <= '0;
            last_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MOD_DMA_AGEN_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            stride_q <= stride_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            idx_q    <= idx_d;
            vld_q    <= vld_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MOD_DMA_AGEN_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    // Pack per-channel registers onto the output buses
    for (genvar g = 0; g < NCH; g++) begin : g_out
        assign addr[g*ADDR_W +: ADDR_W] = addr_q[g];
    end

    assign addr_vld  = vld_q;
    assign addr_last = last_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef MOD_DMA_AGEN_ABORT_EN
    assign aborted   = aborted_q;
`endif

endmodule

// File: doc/mod_dma_agen.md
Name: mod_dma_agen

Overview:
- Parametrised multi-channel DMA address generator for the vision datapath; successor to the fixed two-counter DMA address block.
- Each channel walks base, base+stride, base+2*stride, … for a programmed beat count, with per-channel ready back-pressure.
- A start/busy/done handshake replaces the raw state decoding. Sits between the layer controller and the on-chip feature/weight SRAM ports.

Parameters:
- NCH, 2, number of address channels (1..8).
- ADDR_W, 10, address width per channel.
- LEN_W, 10, beat-count width per channel.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- start  in  1  single-cycle request; sampled only in IDLE.
- cfg_base  in  NCH*ADDR_W  per-channel start address; channel c at bits [c*ADDR_W +: ADDR_W].
- cfg_stride  in  NCH*ADDR_W  per-channel address increment.
- cfg_len  in  NCH*LEN_W  per-channel beat count; 0 means channel disabled.
- ready  in  NCH  per-channel consumer ready.
- addr  out  NCH*ADDR_W  per-channel current address.
- addr_vld  out  NCH  per-channel address valid.
- addr_last  out  NCH  high with the final beat of a channel.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse in DONE.

Behaviour:
- Reset (rst=1 at a clk edge): FSM to IDLE; addr=0, addr_vld=0, addr_last=0, busy=0, done=0, all internal counters 0. Applies mid-RUN; in-flight transfer is discarded with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge T latches cfg_base, cfg_stride and cfg_len into shadow registers.
  - If any latched len≠0, go to RUN; otherwise go to DONE.
  - cfg_* inputs are don't-care outside the start cycle.
- RUN, first cycle (T+1):
  - Every channel with len≠0 drives addr=base, addr_vld=1, and addr_last=(len==1).
  - Channels with len=0 hold addr_vld=0 and addr=0 throughout.
- Beat handshake: a beat on channel c is consumed when addr_vld[c]=1 and ready[c]=1 at a clk edge.
  - On consume, if it was not the last beat: addr ← (addr+stride) mod 2^ADDR_W and beat index +1.
  - On consume of the last beat: addr_vld[c] ← 0 and addr_last[c] ← 0.
  - If ready[c]=0, addr, vld and last hold unchanged.
  - Channels advance independently; no cross-channel coupling.
- Zero-latency throughput: with ready held high, channel c presents exactly len[c] beats in len[c] consecutive cycles.
- RUN → DONE on the edge where the last active channel consumes its final beat.
- DONE: lasts exactly one cycle with done=1 and busy=1, then returns to IDLE. A start asserted during DONE is ignored.
- start in RUN or DONE is ignored; shadow config is not updated.
- Address wrap: addition truncates to ADDR_W bits with no error flag. Example: base=0x3FE, stride=1, ADDR_W=10 gives 0x3FE, 0x3FF, 0x000.
- stride=0 is legal: the same address is repeated len times.
- len is unsigned and the maximum 2^LEN_W−1 is supported. The beat index is LEN_W bits wide and compares against len−1 for last.
- Outputs are registered; no combinational path from ready or start to any output.

Optional Feature:
- Macro: MOD_DMA_AGEN_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 at an edge while in RUN clears all addr_vld and addr_last, zeroes addr, and forces DONE next cycle. done pulses as in normal completion.
  - Adds output aborted (1 bit), high together with done only when the completion was caused by abort.
  - abort in IDLE or DONE is ignored.
  - abort and the final-beat consume on the same edge: abort wins, aborted=1.
- Undefined: neither port exists, and behaviour is exactly as above.

Test Plan:
- Basic run: NCH=2, base0=0x000, stride0=1, len0=4, base1=0x100, stride1=2, len1=3, ready=2'b11, start pulse → ch0 addrs 0,1,2,3 (last on 3); ch1 0x100,0x102,0x104 (last on 0x104); done pulses one cycle after ch0's 4th beat edge; busy high for 5 cycles.
- Back-pressure: as basic run but ready[0] low on cycles 2–3 of RUN → ch0 holds addr=1 with vld=1 for those cycles; ch1 unaffected; done delayed by 2 cycles.
- Wrap and zero-length channel: base0=0x3FE, stride0=1, len0=3, len1=0 → ch0 0x3FE,0x3FF,0x000; addr_vld[1] never asserts; all-zero lens with start → done one cycle after the start edge, no addr_vld.
- Start ignored: start re-pulsed mid-RUN with different cfg → sequence unchanged, exactly one done.
- Reset mid-run: rst=1 on the 2nd beat → next cycle all outputs 0, IDLE, no done; a fresh start then runs normally.
- ABORT (MOD_DMA_AGEN_ABORT_EN): len0=8, abort on the 3rd RUN cycle → vld drops, done=1 and aborted=1 next cycle, then IDLE.
